// File: rtl/ir_pkg.sv
// ir_pkg -- shared definitions for the IR command sequencer.
//   FSM state encoding, NEC frame field offsets, counter widths and a
//   saturating-increment helper used by the error/overflow counters.
package ir_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_ENQ   = 2'd2;

  // NEC frame layout: {~cmd, cmd, ~addr, addr}
  localparam int unsigned FIELD_W   = 8;
  localparam int unsigned ADDR_LSB  = 0;
  localparam int unsigned NADDR_LSB = 8;
  localparam int unsigned CMD_LSB   = 16;
  localparam int unsigned NCMD_LSB  = 24;

  // Counter widths
  localparam int unsigned CNT_W  = 8;   // errCount / ovfCount
  localparam int unsigned HOLD_W = 24;  // repeat-holdoff counter

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ir_cmd_fifo.sv
// ir_cmd_fifo -- small synchronous FIFO holding accepted IR commands.
//   Ports: clk, res (sync, active-high), push/din (write), pop (read),
//          full, empty, head (entry at the read pointer, 0 when empty).
//   A push while full is only taken when a pop happens in the same cycle.
import ir_pkg::*;

module ir_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [OCC_W-1:0] count;
  logic             doPush;
  logic             doPop;

  assign full   = (count == OCC_W'(DEPTH));
  assign empty  = (count == '0);
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);
  assign head   = empty ? '0 : mem[rdPtr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (res) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/ir_cmd_sequencer.sv
// ir_cmd_sequencer -- validates NEC frames from an IR decoder and queues
// the command bytes for a downstream consumer.
//   Ports: clk, res (sync, active-high), code[31:0] (NEC frame),
//          dataValid (frame-valid level), cmdOut/cmdValid/cmdReady
//          (command stream), errCount (bad frames), ovfCount (drops on
//          full queue). Counters saturate at 8'hFF.
//   Build option: define IR_ADDR_FILTER_EN to also require the frame
//   address to equal ADDR_MATCH.
//   Repeated identical commands are suppressed for HOLDOFF cycles after
//   the last accepted one.
import ir_pkg::*;

module ir_cmd_sequencer #(
  parameter logic [FIELD_W-1:0] ADDR_MATCH = 8'h00,
  parameter logic [HOLD_W-1:0]  HOLDOFF    = 24'd5000000,
  parameter int unsigned        FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               res,
  input  logic [31:0]        code,
  input  logic               dataValid,
  output logic [FIELD_W-1:0] cmdOut,
  output logic               cmdValid,
  input  logic               cmdReady,
  output logic [CNT_W-1:0]   errCount,
  output logic [CNT_W-1:0]   ovfCount
);

  logic               dvReg;
  logic               armed;
  logic [1:0]         state;
  logic [31:0]        codeReg;
  logic [HOLD_W-1:0]  holdoff;
  logic [FIELD_W-1:0] lastCmd;

  logic [FIELD_W-1:0] fAddr;
  logic [FIELD_W-1:0] fNAddr;
  logic [FIELD_W-1:0] fCmd;
  logic [FIELD_W-1:0] fNCmd;
  logic               addrOk;
  logic               checkPass;
  logic               isDup;
  logic               frameEvent;
  logic               fifoPush;
  logic               fifoPop;
  logic               fifoFull;
  logic               fifoEmpty;
  logic               pushAccepted;

  assign fAddr  = codeReg[ADDR_LSB  +: FIELD_W];
  assign fNAddr = codeReg[NADDR_LSB +: FIELD_W];
  assign fCmd   = codeReg[CMD_LSB   +: FIELD_W];
  assign fNCmd  = codeReg[NCMD_LSB  +: FIELD_W];

`ifdef IR_ADDR_FILTER_EN
  assign addrOk = (fAddr == ADDR_MATCH);
`else
  logic unusedAddrMatch;
  assign addrOk          = 1'b1;
  assign unusedAddrMatch = ^ADDR_MATCH;
`endif

  assign checkPass = (fNAddr == ~fAddr) && (fNCmd == ~fCmd) && addrOk;
  assign isDup     = (fCmd == lastCmd) && (holdoff != '0);

  // armed stays low after reset until dataValid is seen low, so a level
  // already high when reset releases does not look like a new frame.
  assign frameEvent = dataValid & ~dvReg & armed;

  assign fifoPush     = (state == ST_ENQ);
  assign fifoPop      = cmdValid & cmdReady;
  assign pushAccepted = fifoPush & (~fifoFull | fifoPop);
  assign cmdValid     = ~fifoEmpty;

  always_ff @(posedge clk) begin
    if (res) begin
      dvReg    <= 1'b0;
      armed    <= 1'b0;
      state    <= ST_IDLE;
      codeReg  <= '0;
      holdoff  <= '0;
      lastCmd  <= '0;
      errCount <= '0;
      ovfCount <= '0;
    end else begin
      dvReg <= dataValid;
      if (!dataValid) armed <= 1'b1;

      if (pushAccepted)          holdoff <= HOLDOFF;
      else if (holdoff != '0)    holdoff <= holdoff - HOLD_W'(1);

      case (state)
        ST_IDLE: begin
          if (frameEvent) begin
            codeReg <= code;
            state   <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!checkPass) begin
            errCount <= satInc(errCount);
            state    <= ST_IDLE;
          end else if (isDup) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_ENQ;
          end
        end
        ST_ENQ: begin
          if (pushAccepted) lastCmd  <= fCmd;
          else              ovfCount <= satInc(ovfCount);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ir_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIELD_W)
  ) u_fifo (
    .clk   (clk),
    .res   (res),
    .push  (fifoPush),
    .pop   (fifoPop),
    .din   (fCmd),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .head  (cmdOut)
  );

endmodule

// File: tb/tb_ir_cmd_sequencer.sv
// tb_ir_cmd_sequencer -- bench for ir_cmd_sequencer.
//   A frame-level reference model turns the input stream into expected
//   commands and counter values; a monitor compares them against the
//   command stream and counters on every falling clock edge.
module tb_ir_cmd_sequencer;

  localparam logic [7:0] ADDR  = 8'h00;
  localparam int         HOLD  = 1000;
  localparam int         DEPTH = 4;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic [31:0] code = '0;
  logic        dataValid = 1'b0;
  logic        cmdReady = 1'b1;
  logic [7:0]  cmdOut;
  logic        cmdValid;
  logic [7:0]  errCount;
  logic [7:0]  ovfCount;

  ir_cmd_sequencer #(
    .ADDR_MATCH (ADDR),
    .HOLDOFF    (24'(HOLD)),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .res       (res),
    .code      (code),
    .dataValid (dataValid),
    .cmdOut    (cmdOut),
    .cmdValid  (cmdValid),
    .cmdReady  (cmdReady),
    .errCount  (errCount),
    .ovfCount  (ovfCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  bit randReady = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] nec(input logic [7:0] a, input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  // ---------------- reference model (frame level) ----------------
  int          cyc = 0;
  bit          mArmed, mPrevDv, mPend, mHasAcc;
  logic [31:0] mCode;
  int          mEvt, mLastAccCyc;
  logic [7:0]  mLastCmd;
  int          mOcc, mErr, mOvf;
  logic [7:0]  expQ[$];

  always @(posedge clk) begin
    bit ev, popNow, good;
    logic [7:0] c;
    cyc++;
    if (res) begin
      mArmed = 0; mPrevDv = 0; mPend = 0; mHasAcc = 0;
      mLastCmd = '0; mOcc = 0; mErr = 0; mOvf = 0;
      expQ.delete();
    end else begin
      popNow = (mOcc > 0) && cmdReady;
      ev     = dataValid && !mPrevDv && mArmed;
      c      = mCode[23:16];
      if (mPend && cyc == mEvt + 1) begin
        // frame is valid when it equals the NEC encoding of its own addr/cmd
        good = (mCode == nec(mCode[7:0], mCode[23:16]));
`ifdef IR_ADDR_FILTER_EN
        good = good && (mCode[7:0] == ADDR);
`endif
        if (!good) begin
          if (mErr < 255) mErr++;
          mPend = 0;
        end else if (mHasAcc && c == mLastCmd && (cyc - mLastAccCyc) <= HOLD) begin
          mPend = 0;
        end
      end else if (mPend && cyc == mEvt + 2) begin
        if (mOcc == DEPTH && !popNow) begin
          if (mOvf < 255) mOvf++;
        end else begin
          expQ.push_back(c);
          mOcc++;
          mLastCmd    = c;
          mLastAccCyc = cyc;
          mHasAcc     = 1;
        end
        mPend = 0;
      end else if (!mPend && ev) begin
        mPend = 1;
        mCode = code;
        mEvt  = cyc;
      end
      if (popNow) mOcc--;
      mPrevDv = dataValid;
      if (!dataValid) mArmed = 1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [7:0] e;
    chk("cmdValid", int'(cmdValid), int'(mOcc != 0));
    chk("errCount", int'(errCount), mErr);
    chk("ovfCount", int'(ovfCount), mOvf);
    if (mOcc == 0) chk("cmdOut_empty", int'(cmdOut), 0);
    if (cmdValid && cmdReady && !res) begin
      pops++;
      if (expQ.size() == 0) begin
        chk("unexpected_cmd", int'(cmdOut), -1);
      end else begin
        e = expQ.pop_front();
        chk("cmdOut", int'(cmdOut), int'(e));
      end
    end
  end

  always @(posedge clk) begin
    if (randReady) begin
      #2;
      cmdReady = ($urandom_range(0, 1) == 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic sendFrame(input logic [31:0] c, input int hold, input int gap);
    code      = c;
    dataValid = 1'b1;
    step(hold);
    dataValid = 1'b0;
    step(gap);
  endtask

  initial begin
    int c0, p0, t0, hold, gap;
    logic [7:0] a, cm;
    logic [31:0] f;
    bit seen;

    res = 1'b1;
    step(3);
    res = 1'b0;
    step(2);
    chk("rst_cmdValid", int'(cmdValid), 0);
    chk("rst_cmdOut", int'(cmdOut), 0);
    chk("rst_errCount", int'(errCount), 0);
    chk("rst_ovfCount", int'(ovfCount), 0);

    // first frame: latency and one-cycle pulse with cmdReady high
    code = 32'hBF40FF00;
    dataValid = 1'b1;
    c0 = cyc;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmdValid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("latency_timeout", 0, 1);
    else begin
      chk("latency", cyc - c0, 3);
      chk("first_cmd", int'(cmdOut), 8'h40);
    end
    @(negedge clk);
    chk("pulse_one_cycle", int'(cmdValid), 0);
    step(1);
    dataValid = 1'b0;
    step(3);
    chk("no_err_first", int'(errCount), 0);

    // complement and address failures
    sendFrame(32'hBF41FF00, 2, 6);
    chk("err_bad_ncmd", int'(errCount), 1);
    sendFrame(32'hBF40FE01, 2, 6);
`ifdef IR_ADDR_FILTER_EN
    chk("err_bad_addr", int'(errCount), 2);
`else
    chk("err_bad_addr", int'(errCount), 1);
`endif

    // repeat holdoff
    p0 = pops;
    t0 = cyc;
    sendFrame(nec(ADDR, 8'h22), 2, 0);
    step(t0 + 100 - cyc);
    sendFrame(nec(ADDR, 8'h22), 2, 10);
    chk("dup_dropped", pops - p0, 1);
    step(t0 + 1200 - cyc);
    sendFrame(nec(ADDR, 8'h22), 2, 10);
    chk("dup_after_holdoff", pops - p0, 2);

    // overflow with consumer stalled
    cmdReady = 1'b0;
    p0 = pops;
    for (int i = 1; i <= 5; i++) sendFrame(nec(ADDR, 8'(i)), 2, 4);
    chk("ovf_count", int'(ovfCount), 1);
    chk("ovf_valid", int'(cmdValid), 1);
    chk("ovf_head_stable", int'(cmdOut), 8'h01);
    cmdReady = 1'b1;
    step(8);
    chk("ovf_drained", pops - p0, 4);

    // reset with 3 queued entries and a frame under check
    cmdReady = 1'b0;
    for (int i = 0; i < 3; i++) sendFrame(nec(ADDR, 8'h31 + 8'(i)), 2, 4);
    code = nec(ADDR, 8'h34);
    dataValid = 1'b1;
    step(1);
    res = 1'b1;
    step(1);
    res = 1'b0;
    @(negedge clk);
    chk("midrst_cmdValid", int'(cmdValid), 0);
    chk("midrst_errCount", int'(errCount), 0);
    chk("midrst_ovfCount", int'(ovfCount), 0);
    cmdReady = 1'b1;
    p0 = pops;
    step(20);
    chk("midrst_no_event", pops - p0, 0);
    dataValid = 1'b0;
    step(3);

    // long level: a single event
    p0 = pops;
    sendFrame(nec(ADDR, 8'h77), 10000, 6);
    chk("long_level_one_push", pops - p0, 1);

    // randomized traffic
    randReady = 1'b1;
    for (int n = 0; n < 300; n++) begin
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ADDR;
      cm = 8'h10 + 8'($urandom_range(0, 5));
      f  = nec(a, cm);
      if ($urandom_range(0, 5) == 0) f[$urandom_range(0, 31)] = ~f[$urandom_range(0, 31)];
      hold = $urandom_range(1, 5);
      gap  = (n % 60 == 59) ? 1100 : $urandom_range(3, 40);
      sendFrame(f, hold, gap);
    end
    randReady = 1'b0;
    @(posedge clk);
    #3;
    cmdReady = 1'b1;
    step(20);
    chk("final_drained", int'(cmdValid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    errors++;
    $display("FAIL watchdog: got still running, expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
